// File: rtl/deserializer_1_to_16_align_if.sv
// deserializer_1_to_16_align_if: serial bit input and aligned word output bundle.
// Carries frame_cnt/err_cnt only when DESER_STATS_EN is defined.
interface deserializer_1_to_16_align_if;
    logic        bit_valid;
    logic        bit_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic        locked;
    logic        sync_err;
`ifdef DESER_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
    modport master (output bit_valid, bit_in, input data_out, data_valid, locked, sync_err, frame_cnt, err_cnt);
    modport slave (input bit_valid, bit_in, output data_out, data_valid, locked, sync_err, frame_cnt, err_cnt);
`else
    modport master (output bit_valid, bit_in, input data_out, data_valid, locked, sync_err);
    modport slave (input bit_valid, bit_in, output data_out, data_valid, locked, sync_err);
`endif
endinterface

// File: rtl/deserializer_1_to_16_align.sv
// deserializer_1_to_16_align: MSB-first 1:16 deserializer with sync-word hunt/confirm/lock.
// Optional DESER_STATS_EN adds frame_cnt (wrapping) and err_cnt (saturating) counters.
module deserializer_1_to_16_align #(
    parameter logic [15:0] SYNC_WORD   = 16'hF0A5,
    parameter int          FRAME_WORDS = 4,
    parameter int          MISS_LIMIT  = 2
) (
    input logic clk,
    input logic rst,
    deserializer_1_to_16_align_if.slave bus
);
    localparam logic [1:0] HUNT = 2'd0, CONFIRM = 2'd1, LOCKED = 2'd2;
    localparam logic [7:0] FW = FRAME_WORDS[7:0];
    localparam logic [3:0] ML = MISS_LIMIT[3:0];

    logic [14:0] window_q, window_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] data_out_q, data_out_d, nxt;
    logic        data_valid_q, data_valid_d, sync_err_q, sync_err_d, locked_q, sync_hit;

    assign nxt = {window_q, bus.bit_in};

    always_comb begin
        window_d     = window_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        state_d      = state_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        sync_hit     = 1'b0;
        if (bus.bit_valid) begin
            window_d = nxt[14:0];
            if (state_q == HUNT) begin
                if (nxt == SYNC_WORD) begin
                    bit_cnt_d  = 4'd0;
                    word_cnt_d = 8'd1;
                    state_d    = CONFIRM;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    if (word_cnt_q != 8'd0) begin
                        word_cnt_d   = (word_cnt_q == FW) ? 8'd0 : word_cnt_q + 8'd1;
                        data_out_d   = (state_q == LOCKED) ? nxt : data_out_q;
                        data_valid_d = (state_q == LOCKED);
                    end else if (nxt == SYNC_WORD) begin
                        sync_hit   = 1'b1;
                        state_d    = LOCKED;
                        miss_cnt_d = 4'd0;
                        word_cnt_d = 8'd1;
                    end else if (state_q == CONFIRM) begin
                        state_d = HUNT;
                    end else begin
                        // LOCKED miss: flywheel on the assumed boundary until the miss budget runs out
                        sync_err_d = 1'b1;
                        state_d    = (miss_cnt_q + 4'd1 == ML) ? HUNT : LOCKED;
                        miss_cnt_d = (miss_cnt_q + 4'd1 == ML) ? 4'd0 : miss_cnt_q + 4'd1;
                        word_cnt_d = (miss_cnt_q + 4'd1 == ML) ? 8'd0 : 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            window_q     <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            miss_cnt_q   <= '0;
            state_q      <= HUNT;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            window_q     <= window_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            sync_err_q   <= sync_err_d;
            locked_q     <= (state_q == LOCKED);
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.locked     = locked_q;
    assign bus.sync_err   = sync_err_q;

`ifdef DESER_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;

    always_comb begin
        frame_cnt_d = sync_hit ? frame_cnt_q + 16'd1 : frame_cnt_q;
        err_cnt_d   = (sync_err_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
    assign bus.err_cnt   = err_cnt_q;
`endif
endmodule

// File: tb/tb_deserializer_1_to_16_align.sv
// tb_deserializer_1_to_16_align: scoreboard bench; expected data words are queued as they are
// sent in a locked frame and popped when data_valid pulses.
module tb_deserializer_1_to_16_align;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic gaps = 1'b0;
    logic [15:0] exp_q[$];
    int n_chk = 0, n_pass = 0, n_err = 0, exp_err = 0;

    deserializer_1_to_16_align_if d ();
    deserializer_1_to_16_align dut (.clk(clk), .rst(rst), .bus(d));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && d.data_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", d.data_valid, 1'b0);
            else check("data", d.data_out, exp_q.pop_front());
        end
        if (!rst && d.sync_err) begin
            n_err++;
            check("pulse_excl", d.data_valid, 1'b0);
        end
    end

    task automatic send_bit(input logic b);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                d.bit_valid = 1'b0;
                d.bit_in = 1'($urandom);
                @(posedge clk); #1;
            end
        end
        d.bit_valid = 1'b1;
        d.bit_in = b;
        @(posedge clk); #1;
        d.bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input logic exp);
        if (exp) exp_q.push_back(w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_frame(input logic [15:0] sync, input logic [15:0] base, input logic exp);
        send_word(sync, 1'b0);
        for (int k = 0; k < 4; k++) send_word(base + 16'(k), exp);
    endtask

    task automatic settle();
        d.bit_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] part;
        logic [6:0]  junk;
        d.bit_valid = 1'b0;
        d.bit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_data_out", d.data_out, 16'h0);
        check("rst_data_valid", d.data_valid, 1'b0);
        check("rst_locked", d.locked, 1'b0);
        check("rst_sync_err", d.sync_err, 1'b0);

        // basic lock: first sync only confirms, second locks
        repeat (3) send_bit(1'($urandom));
        send_frame(16'hF0A5, 16'h1111, 1'b0);
        settle();
        check("confirm_not_locked", d.locked, 1'b0);
        send_frame(16'hF0A5, 16'h5555, 1'b1);
        settle();
        check("locked_after_2nd_sync", d.locked, 1'b1);
        send_frame(16'hF0A5, 16'h9990, 1'b1);

        // single sync miss flywheels through
        send_frame(16'hF0A4, 16'hA000, 1'b1);
        exp_err += 1;
        settle();
        check("err_single", n_err, exp_err);
        check("locked_after_1_miss", d.locked, 1'b1);
        send_frame(16'hF0A5, 16'hB000, 1'b1);

        // two consecutive misses drop lock
        send_frame(16'hF0A4, 16'hC000, 1'b1);
        send_frame(16'hF0A4, 16'h3330, 1'b0);
        exp_err += 2;
        settle();
        check("err_double", n_err, exp_err);
        check("unlocked_after_2_miss", d.locked, 1'b0);

        // reset after bit 9 of a word
        part = 16'h1234;
        for (int i = 15; i >= 7; i--) send_bit(part[i]);
        pulse_rst();
        check("midrst_data_out", d.data_out, 16'h0);
        check("midrst_valid", d.data_valid, 1'b0);
        check("midrst_locked", d.locked, 1'b0);
        check("midrst_sync_err", d.sync_err, 1'b0);

        // misaligned start, then gapped and sync-valued data frames
        junk = 7'b1011001;
        for (int i = 6; i >= 0; i--) send_bit(junk[i]);
        send_frame(16'hF0A5, 16'h2220, 1'b0);
        settle();
        check("relock_needs_confirm", d.locked, 1'b0);
        send_frame(16'hF0A5, 16'h6000, 1'b1);
        settle();
        check("misaligned_locked", d.locked, 1'b1);
        gaps = 1'b1;
        send_frame(16'hF0A5, 16'h7000, 1'b1);
        gaps = 1'b0;
        send_frame(16'hF0A5, 16'hF0A5, 1'b1);
        settle();
        check("queue_mid", exp_q.size(), 0);

        // statistics stream: 10 counted syncs then one bad sync
        pulse_rst();
        repeat (5) send_bit(1'b0);
        send_frame(16'hF0A5, 16'h0100, 1'b0);
        for (int f = 0; f < 10; f++) send_frame(16'hF0A5, 16'h0200 + 16'(f * 16), 1'b1);
        send_frame(16'hF0A4, 16'h0400, 1'b1);
        exp_err += 1;
        settle();
        check("stats_locked", d.locked, 1'b1);
`ifdef DESER_STATS_EN
        check("frame_cnt", d.frame_cnt, 16'd10);
        check("err_cnt", d.err_cnt, 16'd1);
`endif
        check("queue_drain", exp_q.size(), 0);
        check("sync_err_total", n_err, exp_err);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/deserializer_1_to_16_align.md
Name: deserializer_1_to_16_align

Overview:
- Receive side of the 16-bit MSB-first serial word link.
- Shifts in one bit per qualified clock and finds word/frame alignment by hunting for a sync word.
- Confirms alignment, then emits 16-bit parallel data words with a one-cycle valid strobe.
- Sits between the bit-recovery stage and the word consumer; mirrors the 16-to-1 serializer on the transmit side.

Parameters:
- SYNC_WORD, 16'hF0A5, frame marker; sent as the first word of every frame, never forwarded.
- FRAME_WORDS, 4, data words per frame following each sync word (legal 1..255).
- MISS_LIMIT, 2, consecutive sync mismatches in LOCKED that force return to HUNT (legal 1..15).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- bit_valid  input  1  qualifies bit_in this cycle; when low, all state holds.
- bit_in  input  1  serial data, MSB of each word first.
- data_out  output  16  last completed data word; holds between strobes.
- data_valid  output  1  one-cycle pulse; data_out is new this cycle.
- locked  output  1  high while in LOCKED.
- sync_err  output  1  one-cycle pulse on a sync mismatch in LOCKED.

Behaviour:
- Reset (rst high at posedge):
  - data_out=0, data_valid=0, locked=0, sync_err=0.
  - Shift window=0, bit_cnt=0, word_cnt=0, miss_cnt=0, state=HUNT.
  - Reset applied mid-frame aborts the current word; no partial word is emitted.
- Shift register: on bit_valid, window <= {window[14:0], bit_in}. Let "next" = {window[14:0], bit_in}.
- bit_cnt (0..15) and word_cnt (0..FRAME_WORDS) advance only on bit_valid, and only outside HUNT.
- Word boundary: bit_valid with bit_cnt==15. At a boundary, bit_cnt wraps to 0. word_cnt==0 marks the sync slot.
- HUNT:
  - Compare next against SYNC_WORD on every valid bit (bit-level sliding search).
  - On match: bit_cnt=0, word_cnt=1, go to CONFIRM.
- CONFIRM:
  - Count words without emitting data.
  - At the boundary with word_cnt==FRAME_WORDS: word_cnt=0.
  - At the boundary with word_cnt==0:
    - next==SYNC_WORD: go to LOCKED, miss_cnt=0, word_cnt=1.
    - Mismatch: go to HUNT. No sync_err pulse. The mismatching bits are not re-searched.
- LOCKED:
  - Boundary with word_cnt in 1..FRAME_WORDS: data_out<=next and data_valid=1 on the following cycle (latency of one clk after the 16th bit's edge). word_cnt increments, or wraps to 0 after FRAME_WORDS.
  - Boundary with word_cnt==0 and next==SYNC_WORD: miss_cnt=0, word_cnt=1.
  - Boundary with word_cnt==0 and a mismatch:
    - sync_err pulses.
    - If miss_cnt+1==MISS_LIMIT: go to HUNT, miss_cnt=0, locked drops the next cycle.
    - Otherwise: miss_cnt increments and the block stays LOCKED, flywheeling with word_cnt=1.
  - A data word equal to SYNC_WORD at a data slot is forwarded normally.
- locked is registered: equals (state==LOCKED) one cycle after the transition.
- data_valid and sync_err are never high in the same cycle.
- Both pulses are 0 when bit_valid was low on the previous edge.
- bit_valid gaps of any length are transparent. Alignment is counted in valid bits, not cycles.

Optional Feature:
- Macro: DESER_STATS_EN.
- When defined, adds two outputs:
  - frame_cnt output 16: increments on each sync match in LOCKED, including the confirming match on the CONFIRM->LOCKED transition; wraps at 16'hFFFF->0.
  - err_cnt output 16: increments on each sync_err pulse; saturates at 16'hFFFF.
  - Both counters reset to 0 on rst. They are not cleared by loss of lock.
- When undefined: these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Basic lock: 3 random bits, then F0A5, 1111, 2222, 3333, 4444, F0A5, 5555, …
  - locked rises after the second F0A5.
  - data_valid pulses with 5555, 6666, …
  - 1111–4444 are not emitted.
- Misaligned start: 7 junk bits, then a frame stream.
  - The sliding hunt still locks.
  - Data words match the sent values exactly; no bit shift.
- Sync loss (MISS_LIMIT=2): once locked, corrupt one sync to F0A4.
  - One sync_err pulse; locked stays high; the next frame's data is still output.
  - Corrupt two consecutive syncs: two sync_err pulses, then locked=0 and state HUNT.
- Gapped input: bit_valid toggled 1-0-0-1 pseudo-randomly during a locked frame.
  - Identical data_out sequence to the gapless run; data_valid appears only after valid bits.
- Reset mid-word: rst for 1 cycle after bit 9 of a data word.
  - All outputs 0 and locked=0 the next cycle.
  - Relock requires a fresh F0A5 plus confirmation.
- With DESER_STATS_EN: 10 good frames then 1 bad sync → frame_cnt=10, err_cnt=1.
- Without DESER_STATS_EN: ports absent, and the same stream gives an identical data_out trace.
